// File: rtl/sync_fifo_pkg.sv
// Shared helpers and reset constants for sync_fifo.
// The optional error flags are enabled by defining SYNC_FIFO_ERR_EN.
package sync_fifo_pkg;

    // Ceiling log2, evaluated at elaboration to cross-check DEPTH against PTR_WIDTH.
    function automatic int unsigned sf_clog2(input int unsigned value);
        int unsigned result;
        logic [32:0] pow;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            pow = 33'(1) << i;
            if (pow < {1'b0, value}) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int unsigned DefPtrWidth = 3;
    typedef logic [DefPtrWidth:0] def_ptr_t;

    localparam logic EmptyRst   = 1'b1;
    localparam logic FullRst    = 1'b0;
    localparam logic AfullRst   = 1'b0;
    localparam logic AemptyRst  = 1'b1;
    localparam logic RvalidRst  = 1'b0;

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo: synchronous write port, registered read port with enable.
// Only the read register is reset; the array itself is not.
module sync_fifo_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count and registered flags around sync_fifo_ram.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow flags with err_clr.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PTR_WIDTH  = 3,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AFULL_LVL  = 6,
    parameter int unsigned AEMPTY_LVL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef SYNC_FIFO_ERR_EN
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow,
`endif
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  r_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count
);

    if (DEPTH != (1 << PTR_WIDTH) || sf_clog2(DEPTH) != PTR_WIDTH) begin : g_bad_depth
        $fatal(1, "sync_fifo: DEPTH must equal 2**PTR_WIDTH");
    end
    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH || AEMPTY_LVL > DEPTH - 1) begin : g_bad_lvl
        $fatal(1, "sync_fifo: almost-full/almost-empty level out of range");
    end

    localparam logic [PTR_WIDTH:0] PtrOne    = {{PTR_WIDTH{1'b0}}, 1'b1};
    localparam logic [PTR_WIDTH:0] DepthCnt  = DEPTH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AfullCnt  = AFULL_LVL[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AemptyCnt = AEMPTY_LVL[PTR_WIDTH:0];

    logic [PTR_WIDTH:0] wptr_q, wptr_d;
    logic [PTR_WIDTH:0] rptr_q, rptr_d;
    logic [PTR_WIDTH:0] count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               afull_q, afull_d;
    logic               aempty_q, aempty_d;
    logic               r_valid_q;
    logic               wr_acc, rd_acc;

    // Accept decisions use the registered flags, so a full FIFO drops a same-cycle write.
    assign wr_acc = w_en & ~full_q;
    assign rd_acc = r_en & ~empty_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_acc) begin
            wptr_d = wptr_q + PtrOne;
        end
        if (rd_acc) begin
            rptr_d = rptr_q + PtrOne;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + PtrOne;
            2'b01:   count_d = count_q - PtrOne;
            default: count_d = count_q;
        endcase
        full_d   = (count_d == DepthCnt);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AfullCnt);
        aempty_d = (count_d <= AemptyCnt);
    end

    // Flags are registered from next-state count so they are glitch-free outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            full_q    <= FullRst;
            empty_q   <= EmptyRst;
            afull_q   <= AfullRst;
            aempty_q  <= AemptyRst;
            r_valid_q <= RvalidRst;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            r_valid_q <= rd_acc;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (wr_acc),
        .waddr_i (wptr_q[PTR_WIDTH-1:0]),
        .wdata_i (data_in),
        .re_i    (rd_acc),
        .raddr_i (rptr_q[PTR_WIDTH-1:0]),
        .rdata_o (data_out)
    );

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Set wins over clear when both happen on the same edge.
    always_comb begin
        overflow_d  = (w_en & full_q) | (overflow_q & ~err_clr);
        underflow_d = (r_en & empty_q) | (underflow_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    assign r_valid      = r_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;

endmodule
